// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: per-register pending-write tracker that sits beside decode.
// It returns stall and bypass decisions for the instruction in decode.
// Fixed-latency writes are tracked with countdown timers and a writeback-slot
// reservation vector. Variable-latency loads are tracked with busy bits and an
// in-flight counter.
module hazard_scoreboard #(
  parameter int NREG = 32,
  parameter int REGW = 5,
  parameter int MAXL = 7,
  parameter int MAXV = 2
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        hold,
  input  logic                        flush,
  input  logic                        issue_valid,
  input  logic                        use_rs,
  input  logic                        use_rt,
  input  logic [REGW-1:0]             rs,
  input  logic [REGW-1:0]             rt,
  input  logic                        wr_en,
  input  logic [REGW-1:0]             rd,
  input  logic [$clog2(MAXL+1)-1:0]   lat,
  input  logic                        vwb_valid,
  input  logic [REGW-1:0]             vwb_rd,
  output logic                        stall,
  output logic                        fwd_rs,
  output logic                        fwd_rt,
  output logic [$clog2(MAXV+1)-1:0]   vcount,
  output logic                        idle
);

  localparam int TW = $clog2(MAXL + 1);
  localparam int VW = $clog2(MAXV + 1);

  logic [TW-1:0] timer_r [NREG];
  logic [TW-1:0] timer_n [NREG];
  logic          vbusy_r [NREG];
  logic          vbusy_n [NREG];
  logic [MAXL:1] res_r;
  logic [MAXL:1] res_n;
  logic [VW-1:0] vcount_r;
  logic [VW-1:0] vcount_n;

  logic rs_counted_s;
  logic rt_counted_s;
  logic rd_nz_s;
  logic raw_s;
  logic waw_s;
  logic port_s;
  logic cap_s;
  logic vwb_eff_s;
  logic accept_s;
  logic var_acc_s;
  logic any_pending_s;

  // Hazard decisions for the instruction currently presented by decode.
  always_comb begin
    rs_counted_s = use_rs & (rs != {REGW{1'b0}});
    rt_counted_s = use_rt & (rt != {REGW{1'b0}});
    rd_nz_s      = wr_en & (rd != {REGW{1'b0}});
    // A completion only frees a slot when its register was really busy;
    // a stray completion must not let a load overrun the in-flight cap.
    vwb_eff_s    = vwb_valid & vbusy_r[vwb_rd];

    raw_s = (rs_counted_s & (vbusy_r[rs] | (timer_r[rs] > TW'(1)))) |
            (rt_counted_s & (vbusy_r[rt] | (timer_r[rt] > TW'(1))));
    waw_s = rd_nz_s & (vbusy_r[rd] | (timer_r[rd] > TW'(1)));

    // Writeback slot lat is taken if something already lands in that cycle,
    // which after this edge's shift is the op now holding slot lat+1.
    port_s = 1'b0;
    for (int i = 1; i < MAXL; i++) begin
      if (rd_nz_s && (lat == TW'(i)) && res_r[i+1]) begin
        port_s = 1'b1;
      end else begin
        port_s = port_s;
      end
    end

    cap_s = rd_nz_s & (lat == {TW{1'b0}}) & (vcount_r == VW'(MAXV)) & ~vwb_eff_s;

    stall    = issue_valid & (raw_s | waw_s | port_s | cap_s);
    fwd_rs   = issue_valid & rs_counted_s & (timer_r[rs] == TW'(1)) & ~vbusy_r[rs];
    fwd_rt   = issue_valid & rt_counted_s & (timer_r[rt] == TW'(1)) & ~vbusy_r[rt];
    accept_s = issue_valid & ~stall & ~flush & ~hold;
    var_acc_s = accept_s & rd_nz_s & (lat == {TW{1'b0}});
  end

  // Next-state: age the fixed timers, then apply completion and acceptance.
  always_comb begin
    for (int r = 0; r < NREG; r++) begin
      if (timer_r[r] != {TW{1'b0}}) begin
        timer_n[r] = timer_r[r] - TW'(1);
      end else begin
        timer_n[r] = {TW{1'b0}};
      end
      vbusy_n[r] = vbusy_r[r];
    end
    res_n = res_r >> 1;

    if (vwb_eff_s) begin
      vbusy_n[vwb_rd] = 1'b0;
    end else begin
      vbusy_n[vwb_rd] = vbusy_n[vwb_rd];
    end

    if (accept_s && rd_nz_s) begin
      if (lat != {TW{1'b0}}) begin
        timer_n[rd] = lat;
        res_n[lat]  = 1'b1;
      end else begin
        vbusy_n[rd] = 1'b1;
      end
    end else begin
      res_n = res_n;
    end

    vcount_n = vcount_r + VW'(var_acc_s) - VW'(vwb_eff_s);
  end

  // State registers; hold freezes everything.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int r = 0; r < NREG; r++) begin
        timer_r[r] <= {TW{1'b0}};
        vbusy_r[r] <= 1'b0;
      end
      res_r    <= {MAXL{1'b0}};
      vcount_r <= {VW{1'b0}};
    end else if (!hold) begin
      for (int r = 0; r < NREG; r++) begin
        timer_r[r] <= timer_n[r];
        vbusy_r[r] <= vbusy_n[r];
      end
      res_r    <= res_n;
      vcount_r <= vcount_n;
    end
  end

  // Idle when nothing of either kind is outstanding.
  always_comb begin
    any_pending_s = 1'b0;
    for (int r = 0; r < NREG; r++) begin
      any_pending_s = any_pending_s | (timer_r[r] != {TW{1'b0}}) | vbusy_r[r];
    end
    vcount = vcount_r;
    idle   = ~any_pending_s & (vcount_r == {VW{1'b0}});
  end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Scoreboard bench for hazard_scoreboard: a reference model tracks each
// register's absolute writeback time and load-busy state; the stimulus side
// pushes predicted outputs and a negedge monitor pops and compares them.
module tb_hazard_scoreboard;
  localparam int NREG = 32, REGW = 5, MAXL = 7, MAXV = 2;
  localparam int TW = $clog2(MAXL + 1), VW = $clog2(MAXV + 1);

  logic clk = 1'b0;
  logic rst, hold, flush, issue_valid, use_rs, use_rt, wr_en, vwb_valid;
  logic [REGW-1:0] rs, rt, rd, vwb_rd;
  logic [TW-1:0] lat;
  logic stall, fwd_rs, fwd_rt, idle;
  logic [VW-1:0] vcount;

  always #5 clk = ~clk;

  hazard_scoreboard #(.NREG(NREG), .REGW(REGW), .MAXL(MAXL), .MAXV(MAXV)) dut (
    .clk(clk), .rst(rst), .hold(hold), .flush(flush), .issue_valid(issue_valid),
    .use_rs(use_rs), .use_rt(use_rt), .rs(rs), .rt(rt), .wr_en(wr_en), .rd(rd),
    .lat(lat), .vwb_valid(vwb_valid), .vwb_rd(vwb_rd), .stall(stall),
    .fwd_rs(fwd_rs), .fwd_rt(fwd_rt), .vcount(vcount), .idle(idle));

  typedef struct {
    logic stall;
    logic fwd_rs;
    logic fwd_rt;
    int   vcount;
    logic idle;
  } exp_t;

  exp_t expq[$];
  exp_t mon_e;
  int checks = 0;
  int errors = 0;

  // Reference model: now counts non-hold edges; due[r] is the tick at which
  // register r's fixed write has fully retired (timer value = due - now).
  int now = 0;
  int due [NREG];
  bit vb  [NREG];
  int vc  = 0;

  function automatic int tmr(int r);
    return (due[r] > now) ? (due[r] - now) : 0;
  endfunction

  function automatic exp_t predict();
    exp_t e;
    bit cs, ct, rdnz, any, pend;
    cs   = use_rs && (rs != 0);
    ct   = use_rt && (rt != 0);
    rdnz = wr_en && (rd != 0);
    any  = 0;
    if (cs && (vb[rs] || tmr(rs) > 1)) any = 1;
    if (ct && (vb[rt] || tmr(rt) > 1)) any = 1;
    if (rdnz && (vb[rd] || tmr(rd) > 1)) any = 1;
    if (rdnz && lat >= 1 && lat < MAXL)
      for (int r = 0; r < NREG; r++) if (tmr(r) == int'(lat) + 1) any = 1;
    if (rdnz && lat == 0 && vc == MAXV && !(vwb_valid && vb[vwb_rd])) any = 1;
    pend = 0;
    for (int r = 0; r < NREG; r++) if (tmr(r) != 0 || vb[r]) pend = 1;
    e.stall  = issue_valid && any;
    e.fwd_rs = issue_valid && cs && tmr(rs) == 1 && !vb[rs];
    e.fwd_rt = issue_valid && ct && tmr(rt) == 1 && !vb[rt];
    e.vcount = vc;
    e.idle   = !pend && vc == 0;
    return e;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, want);
    end
  endtask

  // Monitor: outputs are valid every cycle; compare at the falling edge.
  always @(negedge clk) begin
    if (expq.size() > 0) begin
      mon_e = expq.pop_front();
      chk("stall",  32'(stall),  32'(mon_e.stall));
      chk("fwd_rs", 32'(fwd_rs), 32'(mon_e.fwd_rs));
      chk("fwd_rt", 32'(fwd_rt), 32'(mon_e.fwd_rt));
      chk("vcount", 32'(vcount), 32'(mon_e.vcount));
      chk("idle",   32'(idle),   32'(mon_e.idle));
    end
  end

  task automatic drive(bit iv, bit urs, int a, bit urt, int b, bit w, int d, int l,
                       bit vv, int vr, bit fl, bit hd);
    issue_valid = iv; use_rs = urs; rs = REGW'(a); use_rt = urt; rt = REGW'(b);
    wr_en = w; rd = REGW'(d); lat = TW'(l); vwb_valid = vv; vwb_rd = REGW'(vr);
    flush = fl; hold = hd;
  endtask

  // One cycle: drive, predict, push, then advance the model at the edge.
  task automatic step(bit iv, bit urs, int a, bit urt, int b, bit w, int d, int l,
                      bit vv, int vr, bit fl, bit hd);
    exp_t e;
    bit acc;
    drive(iv, urs, a, urt, b, w, d, l, vv, vr, fl, hd);
    e = predict();
    expq.push_back(e);
    @(posedge clk);
    if (!hd) begin
      acc = iv && !e.stall && !fl;
      now++;
      if (vv && vb[vr]) begin vb[vr] = 0; vc--; end
      if (acc && w && d != 0) begin
        if (l > 0) due[d] = now + l;
        else begin vb[d] = 1; vc++; end
      end
    end
    #1;
  endtask

  task automatic reader(int r, bit hd);
    step(1, 1, r, 0, 0, 0, 0, 0, 0, 0, 0, hd);
  endtask

  task automatic issue(int d, int l);
    step(1, 0, 0, 0, 0, 1, d, l, 0, 0, 0, 0);
  endtask

  // Let everything retire, completing outstanding loads one by one.
  task automatic drain();
    int vr;
    bit vv;
    for (int k = 0; k < 10; k++) begin
      vv = 0; vr = 0;
      for (int r = 1; r < NREG; r++) if (vb[r] && !vv) begin vv = 1; vr = r; end
      step(0, 0, 0, 0, 0, 0, 0, 0, vv, vr, 0, 0);
    end
  endtask

  // Asynchronous reset asserted away from the edge, with a reader of r5 shown.
  task automatic async_reset();
    exp_t e;
    rst = 1'b0;
    drive(1, 1, 5, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int r = 0; r < NREG; r++) begin due[r] = 0; vb[r] = 0; end
    vc = 0;
    #1;
    e = predict();
    expq.push_back(e);
    @(negedge clk);
    @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  initial begin
    int a, b, d, l, vr, c;
    bit vv;
    for (int r = 0; r < NREG; r++) begin due[r] = 0; vb[r] = 0; end
    async_reset();

    // RAW on a 3-cycle op: two stalls then bypass.
    issue(3, 3);
    reader(3, 0); reader(3, 0); reader(3, 0); reader(3, 0);
    drain();

    // Writeback-port collision and retry.
    issue(4, 3); issue(5, 2); issue(5, 2);
    drain();

    // Load capacity, with a same-cycle completion freeing a slot.
    issue(6, 0); issue(7, 0); issue(8, 0);
    step(1, 0, 0, 0, 0, 1, 8, 0, 1, 6, 0, 0);
    reader(6, 0); reader(7, 0);
    drain();

    // Flushed issue changes nothing; hold freezes a pending timer.
    step(1, 0, 0, 0, 0, 1, 8, 2, 0, 0, 1, 0);
    reader(8, 0);
    issue(9, 2);
    reader(9, 1); reader(9, 1); reader(9, 1);
    reader(9, 0); reader(9, 0);
    drain();

    // r0 destination never stalls; WAW on r10.
    issue(0, 0); issue(0, 5); issue(0, 1);
    issue(10, 4);
    for (int k = 0; k < 5; k++) issue(10, 1);
    drain();

    // Mid-run reset while r5 has a timer of 3.
    issue(5, 3);
    async_reset();
    reader(5, 0);

    // Randomized traffic over a small register window.
    for (int k = 0; k < 3000; k++) begin
      vv = 0;
      vr = $urandom_range(0, 15);
      if (vc > 0 && $urandom_range(0, 99) < 35) begin
        for (int t = 0; t < 32; t++) begin
          c = $urandom_range(1, 15);
          if (vb[c] && !vv) begin vr = c; vv = 1; end
        end
      end else if ($urandom_range(0, 99) < 5) begin
        vv = 1;
      end
      a = $urandom_range(0, 15);
      b = $urandom_range(0, 15);
      d = $urandom_range(0, 15);
      l = $urandom_range(0, MAXL);
      step($urandom_range(0, 99) < 80, $urandom_range(0, 1), a, $urandom_range(0, 1), b,
           $urandom_range(0, 99) < 70, d, l, vv, vr,
           $urandom_range(0, 99) < 5, $urandom_range(0, 99) < 5);
      if (k == 1500) async_reset();
    end
    drain();

    @(negedge clk);
    #1;
    chk("queue_drained", 32'(expq.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
